// File: rtl/obufds_ldt_pkg.sv
// Shared types and helpers for the LDT differential serializer.
package obufds_ldt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Counter width, never below one bit.
  function automatic int cw(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/obufds_ldt_bitclk.sv
// Bit-period counter; bit_end_o pulses in the last cycle of each period.
module obufds_ldt_bitclk
  import obufds_ldt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic bit_end_o
);

  localparam int CW = cw(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end_o = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || bit_end_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/obufds_ldt_ser.sv
// LDT differential serializer: start, data LSB first, [parity], stop.
// Parity state enabled by defining OBUFDS_LDT_SER_PARITY_EN.
module obufds_ldt_ser
  import obufds_ldt_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic             C,
  input  logic             CLR_B,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             O,
  output logic             OB,
  output logic             BUSY
);

  localparam int IW = cw(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             stop_q, stop_d;
  logic             o_q, o_d;
  logic             bit_end;
  logic             last_stop;
  logic             accept;
`ifdef OBUFDS_LDT_SER_PARITY_EN
  logic             par_q, par_d;
`endif

  obufds_ldt_bitclk #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bitclk (
    .clk_i    (C),
    .rst_ni   (CLR_B),
    .restart_i(state_q == IDLE),
    .bit_end_o(bit_end)
  );

  assign last_stop = (stop_q == 1'(STOP_BITS - 1));
  assign DIN_READY = (state_q == IDLE) |
                     ((state_q == STOP) & bit_end & last_stop);
  assign accept    = DIN_VALID & DIN_READY;
  assign BUSY      = (state_q != IDLE);
  assign O         = o_q;
  assign OB        = ~o_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
`ifdef OBUFDS_LDT_SER_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      state_d = START;
      sh_d    = DIN;
`ifdef OBUFDS_LDT_SER_PARITY_EN
      par_d   = ^DIN;
`endif
    end else begin
      unique case (state_q)
        IDLE: ;
        START: begin
          if (bit_end) begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            sh_d = sh_q >> 1;
            if (idx_q == IW'(WIDTH - 1)) begin
              idx_d  = '0;
              stop_d = 1'b0;
`ifdef OBUFDS_LDT_SER_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_d = STOP;
            stop_d  = 1'b0;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              state_d = IDLE;
              stop_d  = 1'b0;
            end else begin
              stop_d = stop_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Line level is registered from the next state, so O tracks state_q.
  always_comb begin
    o_d = LINE_IDLE;
    unique case (state_d)
      START:   o_d = LINE_START;
      DATA:    o_d = sh_d[0];
`ifdef OBUFDS_LDT_SER_PARITY_EN
      PARITY:  o_d = par_d;
`endif
      default: o_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge C or negedge CLR_B) begin
    if (!CLR_B) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      o_q     <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      o_q     <= o_d;
    end
  end

`ifdef OBUFDS_LDT_SER_PARITY_EN
  always_ff @(posedge C or negedge CLR_B) begin
    if (!CLR_B) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif

endmodule
